// File: rtl/keypad_pkg.sv
// Shared types, widths and row-decode helpers for the 4x4 keypad scanner.
package keypad_pkg;

  localparam int unsigned KEY_W = 4;
  localparam int unsigned IDX_W = 2;
  localparam int unsigned LINES = 4;
  localparam logic [LINES-1:0] ROWS_RELEASED = 4'b1111;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2
  } state_t;

  // True when exactly one active-low row is asserted.
  function automatic logic row_single(input logic [LINES-1:0] r);
    logic [LINES-1:0] z;
    z = ~r;
    return (z != '0) && ((z & (z - LINES'(1))) == '0);
  endfunction

  // Index of the lowest asserted row; meaningful only when row_single() holds.
  function automatic logic [IDX_W-1:0] row_index(input logic [LINES-1:0] r);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = int'(LINES) - 1; i >= 0; i--) begin
      if (!r[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scan_if.sv
// Keypad matrix lines plus the decoded key stream toward the time-setting logic.
interface keypad_scan_if;
  logic [keypad_pkg::LINES-1:0] row_n;
  logic [keypad_pkg::LINES-1:0] col_n;
  logic [keypad_pkg::KEY_W-1:0] key_code;
  logic                         key_valid;
  logic                         key_held;

  modport master (
    input  row_n,
    output col_n, key_code, key_valid, key_held
  );

  modport slave (
    output row_n,
    input  col_n, key_code, key_valid, key_held
  );
endinterface

// File: rtl/keypad_scan_row_sync.sv
// Two-flop synchronizer for asynchronous active-low keypad rows; resets to idle (all ones).
module row_sync #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '1;
      q      <= '1;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad column scanner with debounce; one key_valid strobe per accepted press.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int unsigned DWELL    = 4,
  parameter int unsigned DEBOUNCE = 5,
  parameter int unsigned RELEASE  = 5
) (
  input logic          scan_clk,
  input logic          rst_n,
  keypad_scan_if.master kp
);

  localparam int unsigned CNT_W = 4;

  logic [LINES-1:0] row_s;
  state_t           state_q, state_d;
  logic [IDX_W-1:0] col_q, col_d, cand_q, cand_d;
  logic [CNT_W-1:0] dwell_q, dwell_d, deb_q, deb_d, rel_q, rel_d;
  logic [KEY_W-1:0] code_q, code_d;
  logic             valid_q, valid_d, held_q, held_d;
  logic [LINES-1:0] col_n_q, col_n_d;
  logic             sample_ok_c, released_c, accept_c;
  logic [IDX_W-1:0] row_idx_c, acc_row_c, col_next_c;

  row_sync #(.W(LINES)) u_row_sync (
    .clk   (scan_clk),
    .rst_n (rst_n),
    .d     (kp.row_n),
    .q     (row_s)
  );

  assign sample_ok_c = row_single(row_s);
  assign row_idx_c   = row_index(row_s);
  assign released_c  = (row_s == ROWS_RELEASED);
  assign col_next_c  = col_q + IDX_W'(1);

  always_ff @(posedge scan_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_SCAN;
      col_q   <= '0;
      cand_q  <= '0;
      dwell_q <= '0;
      deb_q   <= '0;
      rel_q   <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
      held_q  <= 1'b0;
      col_n_q <= 4'b1110;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      cand_q  <= cand_d;
      dwell_q <= dwell_d;
      deb_q   <= deb_d;
      rel_q   <= rel_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      held_q  <= held_d;
      col_n_q <= col_n_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    cand_d    = cand_q;
    dwell_d   = dwell_q;
    deb_d     = deb_q;
    rel_d     = rel_q;
    code_d    = code_q;
    valid_d   = 1'b0;
    held_d    = held_q;
    accept_c  = 1'b0;
    acc_row_c = cand_q;

    unique case (state_q)
      ST_SCAN: begin
        if (dwell_q == CNT_W'(DWELL - 1)) begin
          dwell_d = '0;
          if (sample_ok_c) begin
            cand_d = row_idx_c;
            deb_d  = CNT_W'(1);
            if (DEBOUNCE == 1) begin
              accept_c  = 1'b1;
              acc_row_c = row_idx_c;
            end else begin
              state_d = ST_DEBOUNCE;
            end
          end else begin
            col_d = col_next_c;
          end
        end else begin
          dwell_d = dwell_q + CNT_W'(1);
        end
      end
      ST_DEBOUNCE: begin
        if (sample_ok_c && (row_idx_c == cand_q)) begin
          deb_d = deb_q + CNT_W'(1);
          if (deb_q == CNT_W'(DEBOUNCE - 1)) accept_c = 1'b1;
        end else begin
          state_d = ST_SCAN;
          col_d   = col_next_c;
          dwell_d = '0;
          deb_d   = '0;
        end
      end
      ST_HELD: begin
        // Any non-idle row (bounce or a second key) restarts the release count.
        if (released_c) begin
          if (rel_q == CNT_W'(RELEASE - 1)) begin
            held_d  = 1'b0;
            state_d = ST_SCAN;
            col_d   = col_next_c;
            dwell_d = '0;
            rel_d   = '0;
          end else begin
            rel_d = rel_q + CNT_W'(1);
          end
        end else begin
          rel_d = '0;
        end
      end
      default: begin
        state_d = ST_SCAN;
        dwell_d = '0;
      end
    endcase

    if (accept_c) begin
      state_d = ST_HELD;
      code_d  = {acc_row_c, col_q};
      valid_d = 1'b1;
      held_d  = 1'b1;
      rel_d   = '0;
      deb_d   = '0;
    end

    col_n_d = ~(LINES'(1) << col_d);
  end

  assign kp.col_n     = col_n_q;
  assign kp.key_code  = code_q;
  assign kp.key_valid = valid_q;
  assign kp.key_held  = held_q;

endmodule
